// File: rtl/x_uart_tx.sv
// UART transmitter: valid/ready byte intake into a small FIFO, serialised as 8N1 frames on o_tx.
// Bit period is p_clk_hz/p_baud + 1 cycles, identical to the companion receiver.
//
// state   | meaning
// --------+-----------------------------------------------
// s_idle  | line high, waiting for a queued byte
// s_start | start bit (low)
// s_d0-d7 | data bits, LSB first
// s_stop  | stop bit (high); chains straight into the next start
module x_uart_tx #(
    parameter int p_clk_hz = 1200000,
    parameter int p_baud   = 115200,
    parameter int p_depth  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int timer_top = p_clk_hz / p_baud;
    localparam int tw        = (timer_top > 0) ? $clog2(timer_top + 1) : 1;
    localparam int aw        = $clog2(p_depth);
    localparam int cw        = aw + 1;
    localparam logic [tw-1:0] timer_top_c = tw'(timer_top);
    localparam logic [cw-1:0] depth_c     = cw'(p_depth);

    typedef enum logic [3:0] {
        s_idle  = 4'd0,
        s_start = 4'd1,
        s_d0    = 4'd2,
        s_d1    = 4'd3,
        s_d2    = 4'd4,
        s_d3    = 4'd5,
        s_d4    = 4'd6,
        s_d5    = 4'd7,
        s_d6    = 4'd8,
        s_d7    = 4'd9,
        s_stop  = 4'd10
    } state_t;

    state_t          state_q, state_d;
    logic [tw-1:0]   timer_q, timer_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [p_depth];
    logic [aw-1:0]   wr_ptr_q, rd_ptr_q;
    logic [cw-1:0]   count_q;

    logic            push, pop, fifo_empty, timer_done;

    // Ready comes from the registered count only, so a push offered while full is dropped
    // even when a pop happens in the same cycle.
    assign o_ready    = (count_q != depth_c);
    assign push       = i_valid & o_ready;
    assign fifo_empty = (count_q == '0);
    assign timer_done = (timer_q == timer_top_c);

    assign o_tx   = tx_q;
    assign o_busy = (state_q != s_idle) | ~fifo_empty;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (state_q == s_idle) begin
            timer_d = '0;
            if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = mem_q[rd_ptr_q];
                state_d = s_start;
                tx_d    = 1'b0;
            end
        end else begin
            timer_d = timer_done ? '0 : timer_q + 1'b1;
            if (timer_done) begin
                case (state_q)
                    s_d7: begin
                        state_d = s_stop;
                        tx_d    = 1'b1;
                    end
                    s_stop: begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = s_start;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = s_idle;
                            tx_d    = 1'b1;
                        end
                    end
                    default: begin
                        state_d = state_t'(state_q + 4'd1);
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= s_idle;
            timer_q  <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_x_uart_tx.sv
// Directed bench for x_uart_tx: exact frame timing, back-to-back chaining, FIFO full/drop,
// loopback through a bench-side receiver model, reset mid-frame, and an alternate clock rate.
module tb_x_uart_tx;

    localparam int P = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, tx, busy;
    logic       valid2 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       ready2, tx2, busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    x_uart_tx u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    x_uart_tx #(.p_clk_hz(1152000), .p_baud(115200), .p_depth(4)) u_dut2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid2),
        .i_data  (data2),
        .o_ready (ready2),
        .o_tx    (tx2),
        .o_busy  (busy2)
    );

    // Receiver model: mid-bit sampling with the same bit period, aborted by reset.
    logic [7:0] rx_q [$];
    logic       rx_active = 1'b0;
    int         rx_c = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_ferr = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_active <= 1'b0;
            rx_c      <= 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active <= 1'b1;
                rx_c      <= 1;
            end
        end else begin
            rx_c <= rx_c + 1;
            if (rx_c == P / 2 && tx !== 1'b0) begin
                rx_active <= 1'b0;
            end else if (rx_c % P == P / 2 && rx_c / P >= 1 && rx_c / P <= 8) begin
                rx_sh <= {tx, rx_sh[7:1]};
            end else if (rx_c == 9 * P + P / 2) begin
                rx_active <= 1'b0;
                if (tx === 1'b1) rx_q.push_back(rx_sh);
                else rx_ferr <= rx_ferr + 1;
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
    endtask

    // Current negedge is frame sample index k0 (index 0 = first start-bit cycle).
    task automatic check_frame(input logic [7:0] d, input int k0, input string nm);
        int   errs = 0;
        int   fk = 0;
        logic fg = 1'b0, fb = 1'b0, fe = 1'b0;
        for (int k = k0; k < 10 * P; k++) begin
            int   b;
            logic e;
            b = k / P;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            if (tx !== e || busy !== 1'b1) begin
                if (errs == 0) begin
                    fk = k; fg = tx; fb = busy; fe = e;
                end
                errs++;
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s: %0d bad samples, first at cycle %0d got tx=%b busy=%b want tx=%b busy=1",
                     nm, errs, fk, fg, fb, fe);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b after %0d cycles, want 0", nm, busy, budget);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL push_ready: ready=%b want 1", ready);
        end
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hC3;
        @(negedge clk);
        total++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tx=%b ready=%b busy=%b want 1 1 0", tx, ready, busy);
        end
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_blocks_push: busy=%b tx=%b want 0 1", busy, tx);
        end
    endtask

    task automatic test_single();
        int errs = 0;
        do_reset();
        valid = 1'b1;
        data  = 8'h55;
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (tx !== 1'b1 || busy !== 1'b1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL single_after_push: tx=%b busy=%b ready=%b want 1 1 1", tx, busy, ready);
        end
        @(negedge clk);
        check_frame(8'h55, 0, "single_frame");
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_end: busy=%b tx=%b want 0 1", busy, tx);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL single_idle: %0d cycles not idle-high, want 0", errs);
        end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            bad++;
            $display("FAIL single_rx: got %0d bytes, want 1 byte 0x55", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 1'b1;
        data  = 8'h01;
        @(negedge clk);
        data = 8'h02;
        @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start_latency: tx=%b want 0", tx);
        end
        data = 8'h03;
        @(negedge clk);
        valid = 1'b0;
        check_frame(8'h01, 1, "b2b_frame1");
        check_frame(8'h02, 0, "b2b_frame2");
        check_frame(8'h03, 0, "b2b_frame3");
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL b2b_busy_fall: busy=%b tx=%b want 0 1", busy, tx);
        end
    endtask

    task automatic test_fifo_full();
        int         errs = 0;
        logic [7:0] e5 [5];
        e5 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        do_reset();
        valid = 1'b1;
        data  = 8'h10;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                errs++;
                $display("FAIL full_ready cycle %0d: ready=%b want %b", i, ready, (i < 4));
            end
            data = data + 8'h01;
        end
        valid = 1'b0;
        total++;
        if (errs != 0) bad++;
        wait_idle(800, "full_drain");
        total++;
        if (rx_q.size() != 5) begin
            bad++;
            $display("FAIL full_count: got %0d bytes want 5", rx_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== e5[i]) begin
                bad++;
                $display("FAIL full_order[%0d]: got %h want %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, e5[i]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] e4 [4];
        e4 = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(e4[i]);
        wait_idle(1000, "loop_drain");
        total++;
        if (rx_q.size() != 4) begin
            bad++;
            $display("FAIL loop_count: got %0d bytes want 4", rx_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== e4[i]) begin
                bad++;
                $display("FAIL loop_byte[%0d]: got %h want %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, e4[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        do_reset();
        valid = 1'b1;
        data  = 8'hA1;
        @(negedge clk);
        data = 8'hA2;
        @(negedge clk);
        data = 8'hA3;
        @(negedge clk);
        valid = 1'b0;
        repeat (47) @(negedge clk);
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_d3: tx=%b busy=%b want 0 1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_after_reset: tx=%b ready=%b busy=%b want 1 1 0", tx, ready, busy);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0 || rx_q.size() != 0) begin
            bad++;
            $display("FAIL mid_no_frames: %0d active cycles, %0d bytes, want 0 0", errs, rx_q.size());
        end
    endtask

    task automatic test_param();
        int   edges = 0;
        int   last = 0;
        int   errs = 0;
        logic prev;
        valid2 = 1'b1;
        data2  = 8'h55;
        @(negedge clk);
        valid2 = 1'b0;
        prev = tx2;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx2 !== prev) begin
                if (edges > 0 && c - last != P) begin
                    errs++;
                    $display("FAIL p2_period edge %0d: interval=%0d want %0d", edges, c - last, P);
                end
                last = c;
                edges++;
                prev = tx2;
            end
        end
        total++;
        if (edges != 10) begin
            bad++;
            $display("FAIL p2_edges: got %0d want 10", edges);
        end
        total++;
        if (errs != 0) bad++;
        total++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL p2_idle: tx=%b busy=%b want 1 0", tx2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_loopback();
        test_reset_mid();
        test_param();
        total++;
        if (rx_ferr != 0) begin
            bad++;
            $display("FAIL rx_framing: %0d framing errors want 0", rx_ferr);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
